// File: rtl/core_pkg.sv
// Shared rename-stage definitions: PRF geometry, tag/count types and the
// pointer-wrap helper used by the free list.
package core_pkg;

    localparam int PRF_SIZE  = 16;
    localparam int ARCH_REGS = 4;
    localparam int ID_W      = $clog2(PRF_SIZE);
    localparam int CNT_W     = $clog2(PRF_SIZE + 1);

    typedef logic [ID_W-1:0]  preg_id_t;
    typedef logic [CNT_W-1:0] preg_cnt_t;

    // Tags that start out free (everything not holding an architectural reg).
    localparam int FREE_INIT = PRF_SIZE - ARCH_REGS;

    localparam preg_cnt_t CNT_FULL = preg_cnt_t'(PRF_SIZE);
    localparam preg_cnt_t CNT_RST  = preg_cnt_t'(FREE_INIT);
    localparam preg_id_t  TAIL_RST = (FREE_INIT == PRF_SIZE) ? '0 : preg_id_t'(FREE_INIT);

    // Advance a FIFO pointer, wrapping by explicit compare so PRF_SIZE
    // need not be a power of two.
    function automatic preg_id_t ptr_inc(input preg_id_t p);
        if (p == preg_id_t'(PRF_SIZE - 1)) begin
            return '0;
        end
        return p + preg_id_t'(1);
    endfunction

endpackage

// File: rtl/prf_free_list.sv
// Physical-register free list: circular FIFO of free tags. Rename pops the
// head tag (valid the same cycle), retire pushes superseded tags at the tail.
// Optional double-free detection is enabled with FREE_LIST_DBL_FREE_CHK_EN.
module prf_free_list
    import core_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [ID_W-1:0]  alloc_id,
    input  logic             free_ena,
    input  logic [ID_W-1:0]  free_id,
    output logic [CNT_W-1:0] free_count,
    output logic             err_overflow,
    output logic             err_double_free
);

    preg_id_t  mem_reg  [PRF_SIZE];
    preg_id_t  mem_next [PRF_SIZE];
    preg_id_t  head_reg, head_next;
    preg_id_t  tail_reg, tail_next;
    preg_cnt_t count_reg, count_next;
    logic      err_overflow_reg;

    logic pop;
    logic push;
    logic full;
    logic dbl_hit;

    assign alloc_valid  = (count_reg != '0);
    assign alloc_id     = mem_reg[head_reg];
    assign free_count   = count_reg;
    assign err_overflow = err_overflow_reg;

    assign pop  = alloc_req && alloc_valid;
    assign full = (count_reg == CNT_FULL);
    // Overflowing frees are dropped; a detected double free is never pushed.
    assign push = free_ena && !full && !dbl_hit;

`ifdef FREE_LIST_DBL_FREE_CHK_EN
    logic [PRF_SIZE-1:0] in_list_reg;
    logic [PRF_SIZE-1:0] in_list_next;
    logic                err_double_free_reg;

    // Judge the returned tag against the post-pop view, so retiring a tag
    // that is being allocated in the same cycle is legal.
    assign dbl_hit = free_ena && in_list_reg[free_id] && !(pop && (alloc_id == free_id));

    // Per-tag membership: a push sets, a pop clears; set wins on a same-cycle hit.
    generate
        for (genvar gi = 0; gi < PRF_SIZE; gi++) begin : g_in_list
            assign in_list_next[gi] = (push && (free_id == preg_id_t'(gi))) ? 1'b1 :
                                      (pop && (alloc_id == preg_id_t'(gi))) ? 1'b0 :
                                      in_list_reg[gi];
        end
    endgenerate

    // Membership bitmap and the one-cycle double-free pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                in_list_reg[i] <= (i >= ARCH_REGS);
            end
            err_double_free_reg <= 1'b0;
        end else begin
            in_list_reg         <= in_list_next;
            err_double_free_reg <= dbl_hit;
        end
    end

    assign err_double_free = err_double_free_reg;
`else
    assign dbl_hit         = 1'b0;
    assign err_double_free = 1'b0;
`endif

    // Tail write: only the slot addressed by the tail takes the returned tag.
    generate
        for (genvar gi = 0; gi < PRF_SIZE; gi++) begin : g_mem
            assign mem_next[gi] = (push && (tail_reg == preg_id_t'(gi))) ? free_id : mem_reg[gi];
        end
    endgenerate

    // Pointer and occupancy next-state.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop) begin
            head_next = ptr_inc(head_reg);
        end
        if (push) begin
            tail_next = ptr_inc(tail_reg);
        end
        if (push && !pop) begin
            count_next = count_reg + preg_cnt_t'(1);
        end else if (pop && !push) begin
            count_next = count_reg - preg_cnt_t'(1);
        end
    end

    // FIFO state; reset preloads the non-architectural tags in ascending order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                mem_reg[i] <= (i < FREE_INIT) ? preg_id_t'(ARCH_REGS + i) : '0;
            end
            head_reg         <= '0;
            tail_reg         <= TAIL_RST;
            count_reg        <= CNT_RST;
            err_overflow_reg <= 1'b0;
        end else begin
            mem_reg   <= mem_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            if (free_ena && full) begin
                err_overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list. The reference model is a plain
// queue of free tags; define FREE_LIST_DBL_FREE_CHK_EN to match the DUT build.
module tb_prf_free_list;

    localparam int PRF  = 16;
    localparam int ARCH = 4;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [3:0] alloc_id;
    logic       free_ena;
    logic [3:0] free_id;
    logic [4:0] free_count;
    logic       err_overflow;
    logic       err_double_free;

    prf_free_list dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_id        (alloc_id),
        .free_ena        (free_ena),
        .free_id         (free_id),
        .free_count      (free_count),
        .err_overflow    (err_overflow),
        .err_double_free (err_double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int q[$];
    bit m_ovf;
    bit m_dbl;
    int total = 0;
    int bad   = 0;
    int txn   = 0;

    function automatic bit in_queue(input int qq[$], input int id);
        foreach (qq[k]) if (qq[k] == id) return 1'b1;
        return 1'b0;
    endfunction

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic req, input logic ena, input logic [3:0] id);
        alloc_req = req;
        free_ena  = ena;
        free_id   = id;
        #1;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic edge_step();
        int  tmp[$];
        bit  pop, full, dbl, push;
        if (rst) begin
            q.delete();
            for (int i = ARCH; i < PRF; i++) q.push_back(i);
            m_ovf = 1'b0;
            m_dbl = 1'b0;
        end else begin
            tmp  = q;
            pop  = alloc_req && (q.size() != 0);
            full = (q.size() == PRF);
            if (pop) void'(tmp.pop_front());
`ifdef FREE_LIST_DBL_FREE_CHK_EN
            dbl = free_ena && in_queue(tmp, int'(free_id));
`else
            dbl = 1'b0;
`endif
            if (free_ena && full) m_ovf = 1'b1;
            push = free_ena && !full && !dbl;
            if (push) tmp.push_back(int'(free_id));
            q     = tmp;
            m_dbl = dbl;
        end
        @(posedge clk);
        txn++;
        $display("txn %0d rst=%0b req=%0b ena=%0b id=%0d -> model count=%0d ovf=%0b dbl=%0b",
                 txn, rst, alloc_req, free_ena, free_id, q.size(), m_ovf, m_dbl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0);
        edge_step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 4'd0);
        total++; if (alloc_valid !== 1'b1) begin bad++; $display("FAIL reset_valid got=%0b want=1", alloc_valid); end
        total++; if (alloc_id !== 4'd4) begin bad++; $display("FAIL reset_id got=%0d want=4", alloc_id); end
        total++; if (free_count !== 5'd12) begin bad++; $display("FAIL reset_count got=%0d want=12", free_count); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", err_overflow); end
        total++; if (err_double_free !== 1'b0) begin bad++; $display("FAIL reset_dbl got=%0b want=0", err_double_free); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 4'd0);
            total++; if (alloc_valid !== 1'b1 || alloc_id !== 4'(4 + i)) begin
                bad++; $display("FAIL drain_id[%0d] got=%0b/%0d want=1/%0d", i, alloc_valid, alloc_id, 4 + i);
            end
            edge_step();
        end
        drive(1'b1, 1'b0, 4'd0);
        total++; if (alloc_valid !== 1'b0 || free_count !== 5'd0) begin
            bad++; $display("FAIL drain_empty got=%0b/%0d want=0/0", alloc_valid, free_count);
        end
        edge_step();
        drive(1'b0, 1'b0, 4'd0);
        total++; if (alloc_valid !== 1'b0 || free_count !== 5'd0) begin
            bad++; $display("FAIL drain_13th got=%0b/%0d want=0/0", alloc_valid, free_count);
        end
    endtask

    // Runs from the empty state left by test_drain.
    task automatic test_empty_free();
        drive(1'b1, 1'b1, 4'd7);
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL empty_nobypass got=%0b want=0", alloc_valid); end
        edge_step();
        drive(1'b0, 1'b0, 4'd0);
        total++; if (alloc_valid !== 1'b1 || alloc_id !== 4'd7 || free_count !== 5'd1) begin
            bad++; $display("FAIL empty_free got=%0b/%0d/%0d want=1/7/1", alloc_valid, alloc_id, free_count);
        end
    endtask

    task automatic test_wrap();
        int out[$];
        int idx;
        int fid;
        do_reset();
        out = '{0, 1, 2, 3};
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, out.size() - 1);
            fid = out[idx];
            out.delete(idx);
            drive(1'b1, 1'b1, 4'(fid));
            total++; if (alloc_valid !== 1'b1 || int'(alloc_id) != q[0] || free_count !== 5'd12) begin
                bad++; $display("FAIL wrap[%0d] got=%0b/%0d/%0d want=1/%0d/12", i, alloc_valid, alloc_id, free_count, q[0]);
            end
            out.push_back(q[0]);
            edge_step();
        end
        drive(1'b0, 1'b0, 4'd0);
        total++; if (free_count !== 5'd12 || int'(alloc_id) != q[0]) begin
            bad++; $display("FAIL wrap_end got=%0d/%0d want=12/%0d", free_count, alloc_id, q[0]);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 4'(i));
            edge_step();
        end
        drive(1'b0, 1'b0, 4'd0);
        total++; if (free_count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d want=16", free_count); end
        drive(1'b0, 1'b1, 4'd9);
        edge_step();
        drive(1'b0, 1'b0, 4'd0);
        total++; if (free_count !== 5'd16 || err_overflow !== 1'b1) begin
            bad++; $display("FAIL full_overflow got=%0d/%0b want=16/1", free_count, err_overflow);
        end
        total++; if (err_double_free !== m_dbl) begin
            bad++; $display("FAIL full_dbl got=%0b want=%0b", err_double_free, m_dbl);
        end
        // Drain the FIFO in order and confirm the freed 0..3 come out last.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 4'd0);
            total++; if (alloc_id !== 4'(i < 12 ? i + 4 : i - 12) || err_overflow !== 1'b1) begin
                bad++; $display("FAIL full_order[%0d] got=%0d/%0b want=%0d/1", i, alloc_id, err_overflow, i < 12 ? i + 4 : i - 12);
            end
            edge_step();
        end
        do_reset();
        drive(1'b0, 1'b0, 4'd0);
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_clear got=%0b want=0", err_overflow); end
    endtask

    task automatic test_double_free();
        do_reset();
        drive(1'b0, 1'b1, 4'd5);
        edge_step();
        drive(1'b0, 1'b0, 4'd0);
`ifdef FREE_LIST_DBL_FREE_CHK_EN
        total++; if (free_count !== 5'd12 || err_double_free !== 1'b1) begin
            bad++; $display("FAIL dbl_detect got=%0d/%0b want=12/1", free_count, err_double_free);
        end
`else
        total++; if (free_count !== 5'd13 || err_double_free !== 1'b0) begin
            bad++; $display("FAIL dbl_nochk got=%0d/%0b want=13/0", free_count, err_double_free);
        end
`endif
        edge_step();
        total++; if (err_double_free !== 1'b0) begin bad++; $display("FAIL dbl_pulse got=%0b want=0", err_double_free); end
        // Same-cycle allocate and retire of the head tag is always legal.
        do_reset();
        drive(1'b1, 1'b1, 4'd4);
        edge_step();
        drive(1'b0, 1'b0, 4'd0);
        total++; if (free_count !== 5'd12 || err_double_free !== 1'b0 || alloc_id !== 4'd5) begin
            bad++; $display("FAIL dbl_samecycle got=%0d/%0b/%0d want=12/0/5", free_count, err_double_free, alloc_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                edge_step();
                rst = 1'b0;
            end
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)));
            total++;
            if (alloc_valid !== (q.size() != 0) || free_count !== 5'(q.size()) ||
                (q.size() != 0 && int'(alloc_id) != q[0]) ||
                err_overflow !== m_ovf || err_double_free !== m_dbl) begin
                bad++;
                $display("FAIL rand[%0d] got v=%0b id=%0d cnt=%0d ovf=%0b dbl=%0b want v=%0b id=%0d cnt=%0d ovf=%0b dbl=%0b",
                         i, alloc_valid, alloc_id, free_count, err_overflow, err_double_free,
                         q.size() != 0, (q.size() != 0) ? q[0] : 0, q.size(), m_ovf, m_dbl);
            end
            edge_step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        alloc_req = 1'b0;
        free_ena  = 1'b0;
        free_id   = 4'd0;
        @(negedge clk);
        test_reset();
        test_drain();
        test_empty_free();
        test_wrap();
        test_full();
        test_double_free();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
